// File: rtl/key_event.sv
// ---------------------------------------------------------------------------
// KeyEvent: turns a debounced key level into press/release pulses and
// classifies each gesture as a single click, a double click or a long press.
// The key level is active-low: 1 = released, 0 = pressed.
// One shared counter times both the long-press hold and the double-click gap,
// because the two intervals never run at the same time.
// ---------------------------------------------------------------------------
module key_event #(
    parameter int unsigned LONG_CYC = 50_000_000,
    parameter int unsigned DBL_CYC  = 15_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic shape,
    output logic press_pulse,
    output logic release_pulse,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic hold
);

    // The counter must reach the larger of the two limits without wrapping.
    localparam int unsigned MAX_CYC = (LONG_CYC > DBL_CYC) ? LONG_CYC : DBL_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    // Terminal counts: the timeout fires on the last counted cycle, so the
    // registered pulse appears exactly LONG_CYC / DBL_CYC cycles after the
    // edge that started the interval.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shape_q;

    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             single_q, single_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             hold_q, hold_d;

    logic             fall;
    logic             rise;

    // Edge detection against the previous key level; shape_q resets to the
    // released level so a key already held at reset release reads as a press.
    assign fall = shape_q & ~shape;
    assign rise = ~shape_q & shape;

    // Gesture FSM next-state, counter and pulse decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        single_d  = 1'b0;
        double_d  = 1'b0;
        long_d    = 1'b0;
        press_d   = fall;
        release_d = rise;

        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = PRESS1;
                end
            end

            PRESS1: begin
                // A release landing on the timeout cycle still counts as a
                // short click, so rise is tested before the long timeout.
                if (rise) begin
                    state_d = WAIT2;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            WAIT2: begin
                // A second press landing on the timeout cycle still forms a
                // double click, so fall is tested before the gap timeout.
                if (fall) begin
                    state_d = PRESS2;
                end else if (cnt_q == DBL_LAST) begin
                    state_d  = IDLE;
                    single_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PRESS2: begin
                // No long detection here: a slow second press is still a
                // double click.
                if (rise) begin
                    state_d  = IDLE;
                    double_d = 1'b1;
                end
            end

            LONG: begin
                // The long press was already reported on entry; releasing
                // just ends the gesture silently.
                if (rise) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        hold_d = (state_d == LONG);
    end

    // State, counter, key history and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shape_q   <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            single_q  <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shape_q   <= shape;
            press_q   <= press_d;
            release_q <= release_d;
            single_q  <= single_d;
            double_q  <= double_d;
            long_q    <= long_d;
            hold_q    <= hold_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign single_click  = single_q;
    assign double_click  = double_q;
    assign long_press    = long_q;
    assign hold          = hold_q;

endmodule

// File: tb/tb_key_event.sv
// ---------------------------------------------------------------------------
// Bench for key_event with short timing limits. A timestamp-based gesture
// model predicts every output each cycle; scenario checks pin exact latencies
// and pulse counts with hand-computed numbers.
// ---------------------------------------------------------------------------
module tb_key_event;

    localparam int LONG_CYC = 20;
    localparam int DBL_CYC  = 10;

    logic clk = 1'b0;
    logic rst;
    logic shape;
    logic pressPulse, releasePulse, singleClick, doubleClick, longPress, hold;

    key_event #(
        .LONG_CYC(LONG_CYC),
        .DBL_CYC (DBL_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .shape        (shape),
        .press_pulse  (pressPulse),
        .release_pulse(releasePulse),
        .single_click (singleClick),
        .double_click (doubleClick),
        .long_press   (longPress),
        .hold         (hold)
    );

    always #5 clk = ~clk;

    // Gesture model: the phase of a gesture is derived from how many presses
    // it has seen and the key level, and timeouts from elapsed cycle counts.
    int   cyc      = 0;
    logic mPrev    = 1'b1;
    logic mActive  = 1'b0;
    logic mLong    = 1'b0;
    int   mPresses = 0;
    int   mMark    = 0;
    logic mFall, mRise;
    logic ePress = 0, eRelease = 0, eSingle = 0, eDouble = 0, eLong = 0, eHold = 0;

    // Advance the model on each clock edge; reset wipes any gesture in flight.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPrev = 1'b1; mActive = 1'b0; mLong = 1'b0; mPresses = 0;
            ePress = 0; eRelease = 0; eSingle = 0; eDouble = 0; eLong = 0; eHold = 0;
        end else begin
            cyc      = cyc + 1;
            mFall    = mPrev && !shape;
            mRise    = !mPrev && shape;
            ePress   = mFall;
            eRelease = mRise;
            eSingle  = 0;
            eDouble  = 0;
            eLong    = 0;
            if (!mActive) begin
                if (mFall) begin
                    mActive = 1'b1; mPresses = 1; mMark = cyc;
                end
            end else if (mLong) begin
                if (mRise) begin
                    mActive = 1'b0; mLong = 1'b0;
                end
            end else if (mPresses == 1 && !mPrev) begin
                if (mRise) mMark = cyc;
                else if (cyc - mMark == LONG_CYC) begin
                    eLong = 1; mLong = 1'b1;
                end
            end else if (mPresses == 1) begin
                if (mFall) mPresses = 2;
                else if (cyc - mMark == DBL_CYC) begin
                    eSingle = 1; mActive = 1'b0;
                end
            end else begin
                if (mRise) begin
                    eDouble = 1; mActive = 1'b0;
                end
            end
            eHold = mLong;
            mPrev = shape;
        end
    end

    int errors = 0;
    int checks = 0;
    int pressCnt = 0, releaseCnt = 0, singleCnt = 0, doubleCnt = 0, longCnt = 0, holdCnt = 0;
    int lastPressAt = 0, lastReleaseAt = 0, lastSingleAt = 0, lastDoubleAt = 0, lastLongAt = 0;
    int bPress, bSingle, bDouble, bLong, bHold;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".press_pulse"},   int'(pressPulse),   0);
        checkOutput({tag, ".release_pulse"}, int'(releasePulse), 0);
        checkOutput({tag, ".single_click"},  int'(singleClick),  0);
        checkOutput({tag, ".double_click"},  int'(doubleClick),  0);
        checkOutput({tag, ".long_press"},    int'(longPress),    0);
        checkOutput({tag, ".hold"},          int'(hold),         0);
    endtask

    // Hold the key at a level for exactly n sampling edges.
    task automatic applyStimulus(input logic lvl, input int n);
        shape = lvl;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic snap();
        bPress = pressCnt; bSingle = singleCnt; bDouble = doubleCnt;
        bLong = longCnt; bHold = holdCnt;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        #1;
        checkAllZero("rst_immediate");
        shape = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        shape = 1'b1;
        #1;
        checkAllZero("reset_state");

        // Per-cycle comparison against the model, plus pulse logging.
        fork
            forever begin
                @(negedge clk);
                checkOutput("press_pulse",   int'(pressPulse),   int'(ePress));
                checkOutput("release_pulse", int'(releasePulse), int'(eRelease));
                checkOutput("single_click",  int'(singleClick),  int'(eSingle));
                checkOutput("double_click",  int'(doubleClick),  int'(eDouble));
                checkOutput("long_press",    int'(longPress),    int'(eLong));
                checkOutput("hold",          int'(hold),         int'(eHold));
                if (pressPulse)   begin pressCnt++;   lastPressAt   = cyc; end
                if (releasePulse) begin releaseCnt++; lastReleaseAt = cyc; end
                if (singleClick)  begin singleCnt++;  lastSingleAt  = cyc; end
                if (doubleClick)  begin doubleCnt++;  lastDoubleAt  = cyc; end
                if (longPress)    begin longCnt++;    lastLongAt    = cyc; end
                if (hold)         holdCnt++;
            end
        join_none

        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        applyStimulus(1, 3);

        $display("[TB] short click");
        snap();
        applyStimulus(0, 5);
        applyStimulus(1, 15);
        checkOutput("s1_press_count",   pressCnt - bPress, 1);
        checkOutput("s1_single_count",  singleCnt - bSingle, 1);
        checkOutput("s1_single_delay",  lastSingleAt - lastReleaseAt, 10);
        checkOutput("s1_press_to_rel",  lastReleaseAt - lastPressAt, 5);
        checkOutput("s1_no_double",     doubleCnt - bDouble, 0);
        checkOutput("s1_no_long",       longCnt - bLong, 0);

        $display("[TB] double click");
        snap();
        applyStimulus(0, 5);
        applyStimulus(1, 4);
        applyStimulus(0, 5);
        applyStimulus(1, 15);
        checkOutput("s2_double_count",  doubleCnt - bDouble, 1);
        checkOutput("s2_double_on_rel", lastDoubleAt - lastReleaseAt, 0);
        checkOutput("s2_no_single",     singleCnt - bSingle, 0);

        $display("[TB] long press");
        snap();
        applyStimulus(0, 40);
        applyStimulus(1, 15);
        checkOutput("s3_long_count",    longCnt - bLong, 1);
        checkOutput("s3_long_delay",    lastLongAt - lastPressAt, 20);
        checkOutput("s3_hold_cycles",   holdCnt - bHold, 20);
        checkOutput("s3_no_clicks",     (singleCnt - bSingle) + (doubleCnt - bDouble), 0);

        $display("[TB] release on long timeout cycle");
        snap();
        applyStimulus(0, 20);
        applyStimulus(1, 15);
        checkOutput("s4_no_long",       longCnt - bLong, 0);
        checkOutput("s4_single_count",  singleCnt - bSingle, 1);
        checkOutput("s4_single_delay",  lastSingleAt - lastReleaseAt, 10);

        $display("[TB] second press on gap timeout cycle");
        snap();
        applyStimulus(0, 5);
        applyStimulus(1, 10);
        applyStimulus(0, 3);
        applyStimulus(1, 15);
        checkOutput("s5_no_single",     singleCnt - bSingle, 0);
        checkOutput("s5_double_count",  doubleCnt - bDouble, 1);

        $display("[TB] reset during first press");
        snap();
        applyStimulus(0, 3);
        pulseReset();
        applyStimulus(1, 30);
        checkOutput("s6a_no_events", (singleCnt - bSingle) + (doubleCnt - bDouble) + (longCnt - bLong), 0);

        $display("[TB] reset during release gap");
        snap();
        applyStimulus(0, 3);
        applyStimulus(1, 3);
        pulseReset();
        applyStimulus(1, 30);
        checkOutput("s6b_no_events", (singleCnt - bSingle) + (doubleCnt - bDouble) + (longCnt - bLong), 0);

        $display("[TB] reset while long press held");
        snap();
        applyStimulus(0, 25);
        checkOutput("s6c_hold_before", int'(hold), 1);
        pulseReset();
        applyStimulus(1, 30);
        checkOutput("s6c_one_long", longCnt - bLong, 1);

        $display("[TB] key held through reset release");
        snap();
        rst   = 1'b1;
        shape = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        applyStimulus(0, 3);
        applyStimulus(1, 15);
        checkOutput("s7_press_count",  pressCnt - bPress, 1);
        checkOutput("s7_single_count", singleCnt - bSingle, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
